// File: rtl/alu_cmdq_ctrl.sv
// rtl/alu_cmdq_ctrl.sv - queued ECC ALU command dispatcher with normalisation chaining and watchdog
// Commands are buffered in a DEPTH-entry FIFO and served one at a time by a six-state FSM.
module alu_cmdq_ctrl #(
  parameter int WID   = 256,
  parameter int DEPTH = 4,
  parameter int TAGW  = 4,
  parameter int TOUT  = 4095
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [2:0]                 cmd_op,
  input  logic [1:0]                 cmd_sel,
  input  logic [WID-1:0]             cmd_a,
  input  logic [WID-1:0]             cmd_b,
  input  logic                       cmd_c,
  input  logic                       cmd_swap,
  input  logic [TAGW-1:0]            cmd_tag,
  output logic [1:0]                 eng_sel,
  output logic [WID-1:0]             eng_a,
  output logic [WID-1:0]             eng_b,
  output logic                       eng_c,
  output logic                       eng_swap,
  input  logic [WID-1:0]             r2_in,
  output logic                       fa_start,
  output logic                       mul_start,
  output logic                       inv_start,
  output logic                       sw_start,
  input  logic                       fa_vld,
  input  logic [WID-1:0]             fa_r,
  input  logic                       mul_vld,
  input  logic [WID-1:0]             mul_r,
  input  logic                       inv_vld,
  input  logic [WID-1:0]             inv_r,
  input  logic                       sw_vld,
  input  logic [WID-1:0]             sw_ra,
  input  logic [WID-1:0]             sw_rb,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [WID-1:0]             rsp_r,
  output logic [WID-1:0]             rsp_r2,
  output logic [TAGW-1:0]            rsp_tag,
  output logic [1:0]                 rsp_err,
  output logic [1:0]                 status,
  output logic [$clog2(DEPTH):0]     fifo_cnt
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int WDW = $clog2(TOUT + 1);
  localparam int EW  = 3 + 2 + 2 * WID + 2 + TAGW;

  localparam logic [2:0] OP_FA     = 3'b000;
  localparam logic [2:0] OP_MUL    = 3'b001;
  localparam logic [2:0] OP_INV    = 3'b010;
  localparam logic [2:0] OP_SWAP   = 3'b011;
  localparam logic [2:0] OP_MULRAW = 3'b100;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_OP  = 2'b01;
  localparam logic [1:0] ERR_TMO = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_NISSUE, S_NWAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [EW-1:0]     mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        svc_op_q, svc_op_d;
  logic [1:0]        svc_sel_q, svc_sel_d;
  logic              svc_c_q, svc_c_d, svc_swap_q, svc_swap_d;
  logic [TAGW-1:0]   svc_tag_q, svc_tag_d;
  logic [WID-1:0]    eng_a_q, eng_a_d, eng_b_q, eng_b_d;
  logic [WDW-1:0]    wd_q, wd_d;
  logic [WID-1:0]    rsp_r_q, rsp_r_d, rsp_r2_q, rsp_r2_d;
  logic [TAGW-1:0]   rsp_tag_q, rsp_tag_d;
  logic [1:0]        rsp_err_q, rsp_err_d;
  logic              err_stk_q, err_stk_d;

  logic              push, pop;
  logic [2:0]        h_op;
  logic [1:0]        h_sel;
  logic [WID-1:0]    h_a, h_b;
  logic              h_c, h_swap;
  logic [TAGW-1:0]   h_tag;
  logic              aw_vld;
  logic [WID-1:0]    aw_r;

  assign cmd_ready = (cnt_q != CW'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == S_IDLE) && (cnt_q != '0);
  assign {h_op, h_sel, h_a, h_b, h_c, h_swap, h_tag} = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd_op, cmd_sel, cmd_a, cmd_b, cmd_c, cmd_swap, cmd_tag};
    end
  end

  // Only the engine owning the command in service can complete it; in NWAIT that is always the multiplier.
  always_comb begin
    aw_vld = 1'b0;
    aw_r   = '0;
    if (state_q == S_NWAIT) begin
      aw_vld = mul_vld;
      aw_r   = mul_r;
    end else begin
      case (svc_op_q)
        OP_FA:             begin aw_vld = fa_vld;  aw_r = fa_r;  end
        OP_MUL, OP_MULRAW: begin aw_vld = mul_vld; aw_r = mul_r; end
        OP_INV:            begin aw_vld = inv_vld; aw_r = inv_r; end
        OP_SWAP:           begin aw_vld = sw_vld;  aw_r = sw_ra; end
        default:           begin aw_vld = 1'b0;    aw_r = '0;    end
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d      = cnt_q + CW'(push) - CW'(pop);
    svc_op_d   = svc_op_q;
    svc_sel_d  = svc_sel_q;
    svc_c_d    = svc_c_q;
    svc_swap_d = svc_swap_q;
    svc_tag_d  = svc_tag_q;
    eng_a_d    = eng_a_q;
    eng_b_d    = eng_b_q;
    wd_d       = wd_q;
    rsp_r_d    = rsp_r_q;
    rsp_r2_d   = rsp_r2_q;
    rsp_tag_d  = rsp_tag_q;
    rsp_err_d  = rsp_err_q;
    err_stk_d  = err_stk_q;
    fa_start   = 1'b0;
    mul_start  = 1'b0;
    inv_start  = 1'b0;
    sw_start   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          svc_op_d   = h_op;
          svc_sel_d  = h_sel;
          svc_c_d    = h_c;
          svc_swap_d = h_swap;
          svc_tag_d  = h_tag;
          eng_a_d    = h_a;
          eng_b_d    = h_b;
          if (h_op > OP_MULRAW) begin
            rsp_r_d   = '0;
            rsp_r2_d  = '0;
            rsp_tag_d = h_tag;
            rsp_err_d = ERR_OP;
            err_stk_d = 1'b1;
            state_d   = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        case (svc_op_q)
          OP_FA:             fa_start  = 1'b1;
          OP_MUL, OP_MULRAW: mul_start = 1'b1;
          OP_INV:            inv_start = 1'b1;
          default:           sw_start  = 1'b1;
        endcase
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_NISSUE: begin
        mul_start = 1'b1;
        wd_d      = '0;
        state_d   = S_NWAIT;
      end
      S_WAIT, S_NWAIT: begin
        // A completion in the same cycle the watchdog expires still counts as success.
        if (aw_vld) begin
          if (state_q == S_WAIT && (svc_op_q == OP_MUL || svc_op_q == OP_INV)) begin
            eng_a_d = aw_r;
            eng_b_d = r2_in;
            state_d = S_NISSUE;
          end else begin
            rsp_r_d   = aw_r;
            rsp_r2_d  = (svc_op_q == OP_SWAP) ? sw_rb : '0;
            rsp_tag_d = svc_tag_q;
            rsp_err_d = ERR_OK;
            err_stk_d = 1'b0;
            state_d   = S_RESP;
          end
        end else if (wd_q == WDW'(TOUT - 1)) begin
          rsp_r_d   = '0;
          rsp_r2_d  = '0;
          rsp_tag_d = svc_tag_q;
          rsp_err_d = ERR_TMO;
          err_stk_d = 1'b1;
          state_d   = S_RESP;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      svc_op_q   <= '0;
      svc_sel_q  <= '0;
      svc_c_q    <= 1'b0;
      svc_swap_q <= 1'b0;
      svc_tag_q  <= '0;
      eng_a_q    <= '0;
      eng_b_q    <= '0;
      wd_q       <= '0;
      rsp_r_q    <= '0;
      rsp_r2_q   <= '0;
      rsp_tag_q  <= '0;
      rsp_err_q  <= '0;
      err_stk_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      svc_op_q   <= svc_op_d;
      svc_sel_q  <= svc_sel_d;
      svc_c_q    <= svc_c_d;
      svc_swap_q <= svc_swap_d;
      svc_tag_q  <= svc_tag_d;
      eng_a_q    <= eng_a_d;
      eng_b_q    <= eng_b_d;
      wd_q       <= wd_d;
      rsp_r_q    <= rsp_r_d;
      rsp_r2_q   <= rsp_r2_d;
      rsp_tag_q  <= rsp_tag_d;
      rsp_err_q  <= rsp_err_d;
      err_stk_q  <= err_stk_d;
    end
  end

  always_comb begin
    if (err_stk_q)                              status = 2'b11;
    else if (state_q == S_RESP)                 status = 2'b10;
    else if (state_q == S_IDLE && cnt_q == '0)  status = 2'b00;
    else                                        status = 2'b01;
  end

  assign eng_sel   = svc_sel_q;
  assign eng_a     = eng_a_q;
  assign eng_b     = eng_b_q;
  assign eng_c     = svc_c_q;
  assign eng_swap  = svc_swap_q;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_r     = rsp_r_q;
  assign rsp_r2    = rsp_r2_q;
  assign rsp_tag   = rsp_tag_q;
  assign rsp_err   = rsp_err_q;
  assign fifo_cnt  = cnt_q;

endmodule
